smac_sequencer: RTL and testbench
=================================

Name: smac_sequencer

Overview:
- Cycle-accurate controller for one S-MAC bit-serial datapath.
- Fetches activation/weight bit-planes through a req/ack handshake.
- Drives every batch-0..3 control strobe (input regs, bit reg, ac1, neg, ac2, ac3) from a token pipeline that tracks each accepted plane.
- Computes up to 4 output neurons (ac2/ac3 slots) over a configurable number of M-wide input chunks, then flags each result on out_smac.

Parameters:
M, 16, lanes per bit-plane
Pa, 8, activation bits (two's complement, MSB first); must be >= 2
Pw, 4, weight bits (two's complement, MSB first); must be >= 2
MNO, 288, max inputs per neuron; max chunks NCH = MNO/M
CW, $clog2(MNO/M)+1, chunk counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  job start pulse, sampled in IDLE only
cfg_chunks  in  CW  chunks per neuron, 1..NCH, sampled at start
cfg_slots  in  2  neurons-1 (0..3), sampled at start
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete
plane_req  out  1  plane fetch request
plane_ack  in  1  act/wei plane valid on datapath inputs this cycle
a_bit  out  $clog2(Pa)  requested activation bit index
w_bit  out  $clog2(Pw)  requested weight bit index
chunk_idx  out  CW  requested chunk
slot_idx  out  2  requested neuron slot
w_en_a, w_en_w, w_en_br, MSB_a  out  1 each  batch 0 controls
w_en_ac1, s_en_ac1, cl_en_ac1, MSB_w, w_en_neg  out  1 each  batch 1 controls
valid_ac2, s_en_ac2, cl_en_ac2  out  1 each  batch 2 controls
sel_ac2_ac3  out  2  ac2/ac3 slot select
valid_ac3, cl_en_ac3  out  1 each  batch 3 controls
out_valid  out  1  out_smac holds final result of out_slot
out_slot  out  2  slot of that result
stall_cnt  out  16  see optional feature

Behaviour:
- Clock clk. Reset rst_n is synchronous and active-low. On reset, at any time including mid-job: FSM to IDLE, all tokens killed, all outputs 0.
- FSM states:
  - IDLE: start=1 latches cfg and goes to ISSUE; plane_req rises the next cycle.
  - ISSUE: plane_req=1 until the last plane is accepted, then DRAIN.
  - DRAIN: wait until the token pipeline is empty, pulse done, go to IDLE.
  - start in ISSUE/DRAIN is ignored. busy=1 in ISSUE and DRAIN.
- Fetch order, outer to inner: slot 0..cfg_slots; chunk 0..cfg_chunks-1; w_bit Pw-1..0; a_bit Pa-1..0.
- Address outputs stay stable while plane_req && !plane_ack. They advance the cycle after an accept.
- Accept cycle = plane_req && plane_ack. w_en_a = w_en_w = accept (combinational). No accept = bubble; downstream stages are unaffected.
- Token {a_bit, w_bit, chunk, slot} moves one stage per cycle, with no back-pressure. Timing relative to accept cycle T:
  - T+1: w_en_br=1; MSB_a = (a_bit==Pa-1).
  - T+2: w_en_ac1=1; cl_en_ac1 = (a_bit==Pa-1), else s_en_ac1=1 (shift-then-add).
  - T+3, only if a_bit==0: w_en_neg=1; MSB_w = (w_bit==Pw-1).
  - T+4, only if a_bit==0: valid_ac2=1; cl_en_ac2 = (w_bit==Pw-1), else s_en_ac2=1.
  - T+5, only if a_bit==0 && w_bit==0: valid_ac3=1; cl_en_ac3 = (chunk==0).
  - T+6, only if additionally chunk==cfg_chunks-1: out_valid=1, out_slot = token slot.
- sel_ac2_ac3:
  - = token slot of the ac2 stage when valid_ac2.
  - = token slot of the ac3 stage when valid_ac3.
  - Otherwise holds its last value.
  - valid_ac2 and valid_ac3 never coincide for different slots, guaranteed by Pa>=2. An assertion flags any collision.
- ac1 cl/w of a new token and w_en_neg of the previous token occur on the same edge. This is legal: neg captures the old ac1 value.
- done: pulses the cycle after the final out_valid. busy falls with done.
- Minimum job latency (ack tied 1, 1 slot, 1 chunk):
  - start at cycle 0.
  - Accepts at cycles 1..Pa*Pw.
  - out_valid at Pa*Pw+6; done at Pa*Pw+7.

Optional Feature:
- SMAC_SEQ_STALL_CNT_EN defined:
  - stall_cnt increments on each plane_req && !plane_ack cycle, saturating at 16'hFFFF.
  - Cleared on reset and on job start.
- Undefined: stall_cnt tied to 0; no counter logic.

Test Plan:
- Defaults, ack=1, cfg_slots=0, cfg_chunks=1, start at cycle 0 -> 32 accepts (cycles 1..32); cl_en_ac1 at 3,11,19,27; w_en_neg at 11,19,27,35 with MSB_w only at 11; valid_ac3+cl_en_ac3 at 37; out_valid at 38; done at 39.
- All-ones act and wei planes (act=-1, wei=-1 per lane), 1 chunk -> out_smac = 16 at out_valid; MSB_a asserted on exactly 4 cycles.
- cfg_slots=3, cfg_chunks=18, ack=1 -> 2304 accepts; out_valid pulses for slots 0,1,2,3 in order; cl_en_ac3 count = 4; valid_ac3 count = 72; sel collision assertion never fires.
- ack low for 3 cycles after each 5th request -> addresses held while stalled; same out_smac as the no-stall run; stall_cnt = total stall cycles when the macro is defined, 0 when undefined.
- rst_n=0 for 1 cycle at cycle 20 of a job -> all outputs 0 next cycle; no out_valid; new start runs a clean job matching the first test's timing.
- start pulsed while busy -> ignored; cfg unchanged; single done.

Source files
------------

// File: rtl/smac_sequencer_if.sv
// Plane fetch bus between the S-MAC sequencer and the plane memory.
// The master issues plane_req with a bit/chunk/slot address; the slave acks.
interface smac_sequencer_if #(
    parameter int AW = 3,
    parameter int WW = 2,
    parameter int CW = 6
);
    logic          plane_req;
    logic          plane_ack;
    logic [AW-1:0] a_bit;
    logic [WW-1:0] w_bit;
    logic [CW-1:0] chunk_idx;
    logic [1:0]    slot_idx;

    modport master (
        output plane_req, a_bit, w_bit, chunk_idx, slot_idx,
        input  plane_ack
    );

    modport slave (
        input  plane_req, a_bit, w_bit, chunk_idx, slot_idx,
        output plane_ack
    );
endinterface

// File: rtl/smac_sequencer.sv
// Control sequencer for one bit-serial S-MAC datapath.
// Optional stall counter enabled by defining SMAC_SEQ_STALL_CNT_EN.
module smac_sequencer #(
    parameter int M   = 16,
    parameter int Pa  = 8,
    parameter int Pw  = 4,
    parameter int MNO = 288,
    parameter int CW  = $clog2(MNO / M) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_chunks,
    input  logic [1:0]    cfg_slots,
    output logic          busy,
    output logic          done,
    smac_sequencer_if.master pl,
    output logic          w_en_a,
    output logic          w_en_w,
    output logic          w_en_br,
    output logic          MSB_a,
    output logic          w_en_ac1,
    output logic          s_en_ac1,
    output logic          cl_en_ac1,
    output logic          MSB_w,
    output logic          w_en_neg,
    output logic          valid_ac2,
    output logic          s_en_ac2,
    output logic          cl_en_ac2,
    output logic [1:0]    sel_ac2_ac3,
    output logic          valid_ac3,
    output logic          cl_en_ac3,
    output logic          out_valid,
    output logic [1:0]    out_slot,
    output logic [15:0]   stall_cnt
);
    localparam int AW  = $clog2(Pa);
    localparam int WW  = $clog2(Pw);
    localparam int NCH = MNO / M;
    localparam logic [AW-1:0] A_MSB = AW'(Pa - 1);
    localparam logic [WW-1:0] W_MSB = WW'(Pw - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        logic [CW-1:0] c;
        logic [1:0]    s;
    } tok_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   chunks_q, chunks_d;
    logic [1:0]      slots_q, slots_d;
    tok_t            addr_q, addr_d;
    logic [6:1]      v_q, v_d;
    tok_t [5:1]      t_q, t_d;
    logic [1:0]      s6_q, s6_d;
    logic [1:0]      sel_q, sel_d;
    logic            accept, last;

    assign accept = pl.plane_req && pl.plane_ack;
    assign last   = (addr_q.a == '0) && (addr_q.w == '0) &&
                    (addr_q.c == chunks_q - 1'b1) && (addr_q.s == slots_q);

    always_comb begin
        state_d  = state_q;
        chunks_d = chunks_q;
        slots_d  = slots_q;
        addr_d   = addr_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    chunks_d = cfg_chunks;
                    slots_d  = cfg_slots;
                    addr_d   = '{a: A_MSB, w: W_MSB, c: '0, s: '0};
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (last) state_d = DRAIN;
                    // innermost a_bit, then w_bit, then chunk, then slot
                    addr_d.a = (addr_q.a == '0) ? A_MSB : addr_q.a - 1'b1;
                    if (addr_q.a == '0) begin
                        addr_d.w = (addr_q.w == '0) ? W_MSB : addr_q.w - 1'b1;
                        if (addr_q.w == '0) begin
                            if (addr_q.c == chunks_q - 1'b1) begin
                                addr_d.c = '0;
                                addr_d.s = addr_q.s + 1'b1;
                            end else begin
                                addr_d.c = addr_q.c + 1'b1;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (v_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Token pipeline: later stages only see tokens that finish a word.
    always_comb begin
        v_d[1] = accept;
        v_d[2] = v_q[1];
        v_d[3] = v_q[2] && (t_q[2].a == '0);
        v_d[4] = v_q[3];
        v_d[5] = v_q[4] && (t_q[4].w == '0);
        v_d[6] = v_q[5] && (t_q[5].c == chunks_q - 1'b1);
        t_d[1] = addr_q;
        t_d[2] = t_q[1];
        t_d[3] = t_q[2];
        t_d[4] = t_q[3];
        t_d[5] = t_q[4];
        s6_d   = t_q[5].s;
        sel_d  = sel_q;
        if (v_q[4])      sel_d = t_q[4].s;
        else if (v_q[5]) sel_d = t_q[5].s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            chunks_q <= '0;
            slots_q  <= '0;
            addr_q   <= '0;
            v_q      <= '0;
            t_q      <= '0;
            s6_q     <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            chunks_q <= chunks_d;
            slots_q  <= slots_d;
            addr_q   <= addr_d;
            v_q      <= v_d;
            t_q      <= t_d;
            s6_q     <= s6_d;
            sel_q    <= sel_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign pl.plane_req = (state_q == ISSUE);
    assign pl.a_bit     = addr_q.a;
    assign pl.w_bit     = addr_q.w;
    assign pl.chunk_idx = addr_q.c;
    assign pl.slot_idx  = addr_q.s;

    assign w_en_a      = accept;
    assign w_en_w      = accept;
    assign w_en_br     = v_q[1];
    assign MSB_a       = v_q[1] && (t_q[1].a == A_MSB);
    assign w_en_ac1    = v_q[2];
    assign cl_en_ac1   = v_q[2] && (t_q[2].a == A_MSB);
    assign s_en_ac1    = v_q[2] && (t_q[2].a != A_MSB);
    assign w_en_neg    = v_q[3];
    assign MSB_w       = v_q[3] && (t_q[3].w == W_MSB);
    assign valid_ac2   = v_q[4];
    assign cl_en_ac2   = v_q[4] && (t_q[4].w == W_MSB);
    assign s_en_ac2    = v_q[4] && (t_q[4].w != W_MSB);
    assign valid_ac3   = v_q[5];
    assign cl_en_ac3   = v_q[5] && (t_q[5].c == '0);
    assign out_valid   = v_q[6];
    assign out_slot    = v_q[6] ? s6_q : 2'b00;
    assign sel_ac2_ac3 = sel_d;

`ifdef SMAC_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (pl.plane_req && !pl.plane_ack && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(v_q[4] && v_q[5] && t_q[4].s != t_q[5].s))
                else $error("ac2/ac3 slot select collision");
            assert (!(state_q == IDLE && start) ||
                    (cfg_chunks != '0 && cfg_chunks <= CW'(NCH)))
                else $error("cfg_chunks out of range");
        end
    end
endmodule

// File: tb/tb_smac_sequencer.sv
// Scoreboard bench for smac_sequencer: strobe timing, fetch order, stalls,
// mid-job reset and ignored start.
module tb_smac_sequencer;
    localparam int Pa  = 8;
    localparam int Pw  = 4;
    localparam int M   = 16;
    localparam int MNO = 288;
    localparam int CW  = $clog2(MNO / M) + 1;
    localparam int AW  = $clog2(Pa);
    localparam int WW  = $clog2(Pw);

    logic clk = 1'b0;
    logic rst_n, start;
    logic [CW-1:0] cfg_chunks;
    logic [1:0] cfg_slots;
    logic busy, done;
    logic w_en_a, w_en_w, w_en_br, MSB_a;
    logic w_en_ac1, s_en_ac1, cl_en_ac1, MSB_w, w_en_neg;
    logic valid_ac2, s_en_ac2, cl_en_ac2;
    logic [1:0] sel_ac2_ac3;
    logic valid_ac3, cl_en_ac3, out_valid;
    logic [1:0] out_slot;
    logic [15:0] stall_cnt;

    smac_sequencer_if #(.AW(AW), .WW(WW), .CW(CW)) pif ();

    smac_sequencer #(.M(M), .Pa(Pa), .Pw(Pw), .MNO(MNO), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_chunks(cfg_chunks), .cfg_slots(cfg_slots),
        .busy(busy), .done(done), .pl(pif),
        .w_en_a(w_en_a), .w_en_w(w_en_w), .w_en_br(w_en_br), .MSB_a(MSB_a),
        .w_en_ac1(w_en_ac1), .s_en_ac1(s_en_ac1), .cl_en_ac1(cl_en_ac1),
        .MSB_w(MSB_w), .w_en_neg(w_en_neg),
        .valid_ac2(valid_ac2), .s_en_ac2(s_en_ac2), .cl_en_ac2(cl_en_ac2),
        .sel_ac2_ac3(sel_ac2_ac3), .valid_ac3(valid_ac3), .cl_en_ac3(cl_en_ac3),
        .out_valid(out_valid), .out_slot(out_slot), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int f;
        int s;
    } ev_t;

    ev_t q_br[$], q_a1[$], q_ng[$], q_a2[$], q_a3[$], q_ov[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, s_cyc = 0;
    int ea, ew, ec, es, m_chunks, m_slots;
    int n_acc, n_msba, n_ac3, n_cl3, n_out, n_done;
    int first_acc, last_acc, out_t, done_t;
    int exp_done_t = -1;
    int stall_left = 0;
    bit stall_mode = 0, req_exp = 0, busy_exp = 0, zchk = 0, held_v = 0;
    logic [31:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (stall_mode && stall_left > 0) begin
            pif.plane_ack = 1'b0;
            stall_left--;
        end else begin
            pif.plane_ack = 1'b1;
        end
    end

    always @(negedge clk) begin : mon
        ev_t e;
        bit hit, acc, lst;
        logic [31:0] addr;
        if (zchk) begin
            chk("rst_zero_a", {busy, done, pif.plane_req, pif.a_bit, pif.w_bit,
                pif.chunk_idx, pif.slot_idx}, 0);
            chk("rst_zero_b", {w_en_a, w_en_w, w_en_br, MSB_a, w_en_ac1, s_en_ac1,
                cl_en_ac1, MSB_w, w_en_neg, valid_ac2, s_en_ac2, cl_en_ac2,
                sel_ac2_ac3, valid_ac3, cl_en_ac3, out_valid, out_slot}, 0);
            chk("rst_zero_stall", stall_cnt, 0);
            zchk = 0;
        end
        chk("req", pif.plane_req, req_exp);
        chk("busy", busy, busy_exp);
        chk("done", done, cyc == exp_done_t);
        if (done) begin
            n_done++;
            done_t = cyc;
        end
        acc = pif.plane_req && pif.plane_ack;
        chk("wen", {w_en_a, w_en_w}, {acc, acc});
        addr = {19'd0, pif.a_bit, pif.w_bit, pif.chunk_idx, pif.slot_idx};
        if (held_v && pif.plane_req) chk("hold", addr, held);
        held_v = 0;
        if (pif.plane_req && !pif.plane_ack) begin
            held = addr;
            held_v = 1;
        end

        hit = q_br.size() > 0 && q_br[0].t == cyc;
        if (hit) e = q_br.pop_front();
        chk("br", {w_en_br, MSB_a}, hit ? {1'b1, e.f[0]} : 2'b0);
        hit = q_a1.size() > 0 && q_a1[0].t == cyc;
        if (hit) e = q_a1.pop_front();
        chk("ac1", {w_en_ac1, cl_en_ac1, s_en_ac1},
            hit ? {1'b1, e.f[0], ~e.f[0]} : 3'b0);
        hit = q_ng.size() > 0 && q_ng[0].t == cyc;
        if (hit) e = q_ng.pop_front();
        chk("neg", {w_en_neg, MSB_w}, hit ? {1'b1, e.f[0]} : 2'b0);
        hit = q_a2.size() > 0 && q_a2[0].t == cyc;
        if (hit) e = q_a2.pop_front();
        chk("ac2", {valid_ac2, cl_en_ac2, s_en_ac2},
            hit ? {1'b1, e.f[0], ~e.f[0]} : 3'b0);
        if (hit) chk("sel2", sel_ac2_ac3, e.s);
        hit = q_a3.size() > 0 && q_a3[0].t == cyc;
        if (hit) e = q_a3.pop_front();
        chk("ac3", {valid_ac3, cl_en_ac3}, hit ? {1'b1, e.f[0]} : 2'b0);
        if (hit) chk("sel3", sel_ac2_ac3, e.s);
        hit = q_ov.size() > 0 && q_ov[0].t == cyc;
        if (hit) e = q_ov.pop_front();
        chk("out", {out_valid, out_slot}, hit ? {1'b1, 2'(e.s)} : 3'b0);

        if (MSB_a) n_msba++;
        if (valid_ac3) n_ac3++;
        if (cl_en_ac3) n_cl3++;
        if (out_valid) begin
            n_out++;
            out_t = cyc;
        end

        if (acc) begin
            chk("addr_a", pif.a_bit, ea);
            chk("addr_w", pif.w_bit, ew);
            chk("addr_c", pif.chunk_idx, ec);
            chk("addr_s", pif.slot_idx, es);
            if (n_acc == 0) first_acc = cyc;
            last_acc = cyc;
            n_acc++;
            q_br.push_back('{cyc + 1, int'(ea == Pa - 1), es});
            q_a1.push_back('{cyc + 2, int'(ea == Pa - 1), es});
            if (ea == 0) begin
                q_ng.push_back('{cyc + 3, int'(ew == Pw - 1), es});
                q_a2.push_back('{cyc + 4, int'(ew == Pw - 1), es});
                if (ew == 0) begin
                    q_a3.push_back('{cyc + 5, int'(ec == 0), es});
                    if (ec == m_chunks - 1) q_ov.push_back('{cyc + 6, 0, es});
                end
            end
            lst = ea == 0 && ew == 0 && ec == m_chunks - 1 && es == m_slots;
            if (lst) begin
                req_exp = 0;
                exp_done_t = cyc + 7;
            end
            if (ea > 0) ea--;
            else begin
                ea = Pa - 1;
                if (ew > 0) ew--;
                else begin
                    ew = Pw - 1;
                    if (ec < m_chunks - 1) ec++;
                    else begin
                        ec = 0;
                        es++;
                    end
                end
            end
            if (stall_mode && n_acc % 5 == 0) stall_left = 3;
        end
        if (cyc == exp_done_t) busy_exp = 0;
        if (!rst_n) begin
            q_br.delete(); q_a1.delete(); q_ng.delete();
            q_a2.delete(); q_a3.delete(); q_ov.delete();
            zchk = 1;
            req_exp = 0;
            busy_exp = 0;
            exp_done_t = -1;
            held_v = 0;
            stall_left = 0;
        end
    end

    task automatic run_job(input int sl, input int ch, input bit stl,
                           input int rst_at, input bit poke);
        bit fin;
        m_slots = sl; m_chunks = ch;
        ea = Pa - 1; ew = Pw - 1; ec = 0; es = 0;
        n_acc = 0; n_msba = 0; n_ac3 = 0; n_cl3 = 0; n_out = 0; n_done = 0;
        first_acc = -1; last_acc = -1; out_t = -1; done_t = -1;
        stall_mode = stl;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_slots = 2'(sl);
        cfg_chunks = CW'(ch);
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_slots = 2'(~sl);
        cfg_chunks = CW'(3);
        req_exp = 1;
        busy_exp = 1;
        fin = 0;
        for (int k = 0; k < 6000; k++) begin
            if (rst_at == 0 && n_done > 0) begin
                fin = 1;
                break;
            end
            if (rst_at != 0 && cyc > s_cyc + rst_at + 4) begin
                fin = 1;
                break;
            end
            rst_n = !(rst_at != 0 && cyc == s_cyc + rst_at);
            if (poke && cyc == s_cyc + 10) begin
                start = 1'b1;
                cfg_slots = 2'd3;
                cfg_chunks = CW'(5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        start = 1'b0;
        stall_mode = 0;
        chk("job_end", fin, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", q_br.size() + q_a1.size() + q_ng.size() +
            q_a2.size() + q_a3.size() + q_ov.size(), 0);
    endtask

    task automatic t1_checks(input string tag);
        chk({tag, "_first"}, first_acc - s_cyc, 1);
        chk({tag, "_last"}, last_acc - s_cyc, Pa * Pw);
        chk({tag, "_out"}, out_t - s_cyc, Pa * Pw + 6);
        chk({tag, "_done"}, done_t - s_cyc, Pa * Pw + 7);
        chk({tag, "_nacc"}, n_acc, Pa * Pw);
        chk({tag, "_msba"}, n_msba, Pw);
        chk({tag, "_nout"}, n_out, 1);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin
        int exp_stall;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_chunks = CW'(1);
        cfg_slots = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_job(0, 1, 0, 0, 0);
        t1_checks("t1");

        run_job(3, 18, 0, 0, 0);
        chk("big_nacc", n_acc, 4 * 18 * Pa * Pw);
        chk("big_nout", n_out, 4);
        chk("big_ac3", n_ac3, 72);
        chk("big_cl3", n_cl3, 4);
        chk("big_ndone", n_done, 1);

        run_job(0, 2, 1, 0, 0);
        chk("stl_nacc", n_acc, 2 * Pa * Pw);
        chk("stl_nout", n_out, 1);
`ifdef SMAC_SEQ_STALL_CNT_EN
        exp_stall = 3 * (2 * Pa * Pw / 5) - (((2 * Pa * Pw) % 5 == 0) ? 3 : 0);
`else
        exp_stall = 0;
`endif
        chk("stl_cnt", stall_cnt, exp_stall);

        run_job(0, 1, 0, 20, 0);
        chk("rst_nout", n_out, 0);
        chk("rst_ndone", n_done, 0);

        run_job(0, 1, 0, 0, 0);
        t1_checks("t1b");

        run_job(1, 1, 0, 0, 1);
        chk("poke_nacc", n_acc, 2 * Pa * Pw);
        chk("poke_nout", n_out, 2);
        chk("poke_ndone", n_done, 1);

        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
